// File: rtl/riscv_pkg.sv
// Shared front-end types and constants.
//   fetch_entry_t : payload of one fetched instruction slot
//   FETCH_PC_STEP : byte stride between sequential fetch addresses
package riscv_pkg;

  localparam int unsigned FETCH_ILEN    = 32;
  localparam int unsigned FETCH_PC_STEP = 4;

  typedef struct packed {
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Instruction storage FIFO for the fetch queue (module fetch_fifo).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_flush           drop all entries (pointers and count to zero)
//   i_push, i_data    write one entry at the tail
//   i_pop             retire the head entry (caller guarantees non-empty)
//   o_data            head entry contents
//   o_count           current occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Data array carries no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches under a credit limit,
// buffers in-order responses and presents them with their PCs.
// Optional feature macro: FETCH_BYPASS_EN (empty-queue response bypass).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   redirect_i, redirect_pc_i        flush fetch state and restart at new PC
//   imem_req_o, imem_addr_o          fetch request / address
//   imem_gnt_i                       request accepted
//   imem_rvalid_i, imem_rdata_i      in-order response
//   out_valid_o, out_pc_o, out_instr_o, out_ready_i   consumer handshake
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      ILEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             out_valid_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [ILEN-1:0]  out_instr_o,
  input  logic             out_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  localparam logic ST_FETCH = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  logic            r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_out_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_disc;

  logic            w_state_nxt;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] w_out_pc_nxt;
  logic [CW-1:0]   w_outst_nxt;
  logic [CW-1:0]   w_disc_nxt;

  logic [CW-1:0]   w_count;
  logic [ILEN-1:0] w_fifo_data;
  logic            w_fifo_valid;
  logic            w_fire;
  logic            w_push;
  logic            w_pop_fifo;
  logic            w_pop_any;
  logic            w_bypass;
  logic            w_credit;

  // Credit uses registered counts only, so a pop frees a slot next cycle.
  assign w_credit   = (SW'(w_count) + SW'(r_outst)) < SW'(DEPTH);
  assign imem_req_o = !rst && (r_state == ST_FETCH) && !redirect_i && w_credit;
  assign imem_addr_o = r_fetch_pc;
  assign w_fire     = imem_req_o && imem_gnt_i;

  assign w_fifo_valid = (w_count != '0);

`ifdef FETCH_BYPASS_EN
  // Empty queue: hand a live response straight to the consumer.
  assign w_bypass = !w_fifo_valid && (r_disc == '0) && imem_rvalid_i && !redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid_o = !rst && (w_fifo_valid || w_bypass);
  assign out_instr_o = w_bypass ? imem_rdata_i : w_fifo_data;
  assign out_pc_o    = r_out_pc;

  // A redirect discards the response and ignores any pop in the same cycle.
  assign w_pop_any  = out_valid_o && out_ready_i && !redirect_i;
  assign w_pop_fifo = w_pop_any && w_fifo_valid;
  assign w_push     = imem_rvalid_i && (r_disc == '0) && !redirect_i &&
                      !(w_bypass && out_ready_i);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ILEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_data  (imem_rdata_i),
    .i_pop   (w_pop_fifo),
    .o_data  (w_fifo_data),
    .o_count (w_count)
  );

  // Next-state and counter/PC update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_out_pc_nxt   = r_out_pc;
    w_outst_nxt    = r_outst + CW'(w_fire) - CW'(imem_rvalid_i);
    w_disc_nxt     = r_disc;

    if (w_fire)    w_fetch_pc_nxt = r_fetch_pc + XLEN'(FETCH_PC_STEP);
    if (w_pop_any) w_out_pc_nxt   = r_out_pc + XLEN'(FETCH_PC_STEP);
    if (imem_rvalid_i && (r_disc != '0)) w_disc_nxt = r_disc - CW'(1);

    if (redirect_i) begin
      // Everything still in flight after this cycle is stale.
      w_fetch_pc_nxt = redirect_pc_i;
      w_out_pc_nxt   = redirect_pc_i;
      w_disc_nxt     = w_outst_nxt;
      w_state_nxt    = (w_outst_nxt != '0) ? ST_FLUSH : ST_FETCH;
    end else if ((r_state == ST_FLUSH) && (w_disc_nxt == '0)) begin
      w_state_nxt = ST_FETCH;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= RESET_PC;
      r_outst    <= '0;
      r_disc     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_out_pc   <= w_out_pc_nxt;
      r_outst    <= w_outst_nxt;
      r_disc     <= w_disc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [XLEN-1:0] addr;
    bit              stale;
  } mem_ent_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } sb_ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             imem_req_o;
  logic [XLEN-1:0]  imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [ILEN-1:0]  imem_rdata_i;
  logic             out_valid_o;
  logic [XLEN-1:0]  out_pc_o;
  logic [ILEN-1:0]  out_instr_o;
  logic             out_ready_i;

  int total = 0;
  int bad   = 0;

  mem_ent_t        mem_q[$];
  sb_ent_t         sb[$];
  logic [XLEN-1:0] popped[$];
  logic [XLEN-1:0] m_pc;
  bit              mem_en;
  int              grants;
  int              pushes;
  logic            t_req;
  logic            t_valid;
  logic [XLEN-1:0] t_addr;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .out_valid_o   (out_valid_o),
    .out_pc_o      (out_pc_o),
    .out_instr_o   (out_instr_o),
    .out_ready_i   (out_ready_i)
  );

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return ILEN'(a[31:0] ^ 32'hC0DE_0013);
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, check outputs against the model,
  // update the model with this cycle's events, advance past the edge.
  task automatic tick();
    bit       any_stale;
    bit       exp_req;
    bit       exp_valid;
    bit       resp;
    bit       pop;
    bit       fire;
    mem_ent_t m;
    sb_ent_t  s;
    imem_rvalid_i = mem_en && (mem_q.size() > 0);
    imem_rdata_i  = (mem_q.size() > 0) ? instr_of(mem_q[0].addr) : '0;
    #1;
    t_req   = imem_req_o;
    t_valid = out_valid_o;
    t_addr  = imem_addr_o;
    if (rst) begin
      chk("rst_req", 64'(imem_req_o), 64'(0));
      chk("rst_valid", 64'(out_valid_o), 64'(0));
      mem_q.delete();
      sb.delete();
      m_pc = '0;
    end else begin
      any_stale = 0;
      foreach (mem_q[i]) if (mem_q[i].stale) any_stale = 1;
      exp_req = !redirect_i && !any_stale && ((sb.size() + mem_q.size()) < DEPTH);
      chk("req", 64'(imem_req_o), 64'(exp_req));
      if (exp_req) chk("addr", imem_addr_o, m_pc);
      resp = imem_rvalid_i;
      exp_valid = (sb.size() != 0);
`ifdef FETCH_BYPASS_EN
      if (resp && !mem_q[0].stale && !redirect_i) exp_valid = 1;
`endif
      chk("valid", 64'(out_valid_o), 64'(exp_valid));
      pop  = out_valid_o && out_ready_i && !redirect_i;
      fire = imem_req_o && imem_gnt_i;
      if (resp) begin
        m = mem_q.pop_front();
        if (!m.stale && !redirect_i) begin
          s.pc    = m.addr;
          s.instr = instr_of(m.addr);
          sb.push_back(s);
          pushes++;
        end
      end
      if (pop) begin
        if (sb.size() == 0) begin
          chk("pop_nonempty", 64'(0), 64'(1));
        end else begin
          s = sb.pop_front();
          chk("out_pc", out_pc_o, s.pc);
          chk("out_instr", 64'(out_instr_o), 64'(s.instr));
          popped.push_back(out_pc_o);
        end
      end
      if (fire) begin
        m.addr  = m_pc;
        m.stale = 0;
        mem_q.push_back(m);
        m_pc = m_pc + 64'd4;
        grants++;
      end
      if (redirect_i) begin
        sb.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1;
        m_pc = redirect_pc_i;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    imem_gnt_i  = 0;
    out_ready_i = 1;
    mem_en      = 1;
    for (int k = 0; k < 40 && (sb.size() + mem_q.size()) > 0; k++) tick();
    chk("drain_empty", 64'(sb.size() + mem_q.size()), 64'(0));
  endtask

  logic [XLEN-1:0] a0;
  int              p0;

  initial begin
    rst = 1; redirect_i = 0; redirect_pc_i = '0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    out_ready_i = 0; mem_en = 1; grants = 0; pushes = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick();
    rst = 0;

    // Streaming fetch: addresses and PCs 0,4,8,...
    imem_gnt_i = 1; out_ready_i = 1; mem_en = 1;
    tick();
    chk("first_req", 64'(t_req), 64'(1));
    chk("first_addr", t_addr, 64'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("stream_first_pc", popped[0], 64'h0);
    chk("stream_third_pc", popped[2], 64'h8);

    // Credit limit with a stalled consumer.
    drain();
    grants = 0;
    out_ready_i = 0; imem_gnt_i = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("credit_grants", 64'(grants), 64'(DEPTH));
    chk("credit_req_low", 64'(t_req), 64'(0));
    out_ready_i = 1;
    tick();
    tick();
    chk("credit_resume", 64'(t_req), 64'(1));
    for (int i = 0; i < 6; i++) tick();

    // Grant withheld: address holds, nothing pushed.
    drain();
    imem_gnt_i = 0;
    tick();
    a0 = t_addr;
    p0 = pushes;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_addr", t_addr, a0);
      chk("hold_req", 64'(t_req), 64'(1));
    end
    chk("hold_pushes", 64'(pushes), 64'(p0));

    // Redirect with two outstanding requests.
    mem_en = 0; imem_gnt_i = 1;
    tick(); tick();
    chk("two_outst", 64'(mem_q.size()), 64'(2));
    imem_gnt_i = 0; redirect_i = 1; redirect_pc_i = 64'h1000;
    tick();
    redirect_i = 0; mem_en = 1;
    tick();
    chk("flush_req", 64'(t_req), 64'(0));
    tick();
    chk("flush_no_valid", 64'(t_valid), 64'(0));
    popped.delete();
    imem_gnt_i = 1;
    tick();
    chk("redir_addr", t_addr, 64'h1000);
    for (int i = 0; i < 6; i++) tick();
    chk("redir_out_pc", popped[0], 64'h1000);

    // Redirect coinciding with a response and a pop.
    drain();
    out_ready_i = 0; imem_gnt_i = 1;
    tick(); tick();
    imem_gnt_i = 0; out_ready_i = 1; redirect_i = 1; redirect_pc_i = 64'h2000;
    tick();
    chk("collide_resp", 64'(imem_rvalid_i), 64'(1));
    redirect_i = 0;
    tick();
    chk("collide_empty", 64'(t_valid), 64'(0));
    imem_gnt_i = 1;
    popped.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("collide_pc", popped[0], 64'h2000);

    // Response-to-output latency from an empty queue.
    drain();
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    tick();
`ifdef FETCH_BYPASS_EN
    chk("lat_same", 64'(t_valid), 64'(1));
    tick();
    chk("lat_next", 64'(t_valid), 64'(0));
`else
    chk("lat_same", 64'(t_valid), 64'(0));
    tick();
    chk("lat_next", 64'(t_valid), 64'(1));
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, 64, address/PC width.
REQ-002 Parameter ILEN, 32, instruction width.
REQ-003 Parameter DEPTH, 4, queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, 64'h0, first fetch address.
REQ-005 One clock; reset is synchronous and active-high. Ports follow, one per line.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 redirect_i  in  1  discard all fetch state; restart at redirect_pc_i.
REQ-009 redirect_pc_i  in  XLEN  new fetch address.
REQ-010 imem_req_o  out  1  fetch request valid.
REQ-011 imem_addr_o  out  XLEN  fetch address.
REQ-012 imem_gnt_i  in  1  request accepted this cycle.
REQ-013 imem_rvalid_i  in  1  in-order response valid.
REQ-014 imem_rdata_i  in  ILEN  response instruction.
REQ-015 out_valid_o  out  1  head entry valid.
REQ-016 out_pc_o  out  XLEN  PC of head entry.
REQ-017 out_instr_o  out  ILEN  head instruction.
REQ-018 out_ready_i  in  1  consumer accepts head; pop on out_valid_o&&out_ready_i.

Function
REQ-019 FSM states FETCH and FLUSH; FETCH issues requests, FLUSH issues none.
REQ-020 Credit rule: imem_req_o = (state==FETCH) && !redirect_i && (occupancy + outstanding < DEPTH), using registered counts; a pop frees credit next cycle.
REQ-021 imem_addr_o = fetch_pc; on req&&gnt, fetch_pc += 4 (mod 2^XLEN), outstanding += 1.
REQ-022 imem_addr_o stable while imem_req_o high and not granted.
REQ-023 Response with discard_cnt==0 is pushed at queue tail; outstanding -= 1.
REQ-024 Response with discard_cnt>0 is dropped; discard_cnt -= 1, outstanding -= 1.
REQ-025 Push-to-out_valid_o latency: 1 cycle (bypass off).
REQ-026 out_pc_o register: loaded with RESET_PC/redirect_pc_i, += 4 on each pop.
REQ-027 Redirect: queue emptied, fetch_pc and out_pc loaded with redirect_pc_i, discard_cnt <= outstanding after this cycle's grant/response updates; next state FLUSH if that value >0, else FETCH.
REQ-028 Redirect in same cycle as rvalid: response dropped; as pop: pop ignored; as gnt: granted request counted as discard.
REQ-029 Redirect while in FLUSH: PCs reloaded, discard_cnt continues; no queue change.
REQ-030 FLUSH -> FETCH when discard_cnt reaches 0.
REQ-031 Full: occupancy==DEPTH never receives a push (guaranteed by credit rule); empty: out_valid_o=0.
REQ-032 Read/write pointers wrap modulo DEPTH; simultaneous push and pop at any occupancy legal.

Reset
REQ-033 rst: state FETCH, fetch_pc=out_pc=RESET_PC, occupancy=outstanding=discard_cnt=0, pointers 0.
REQ-034 During rst imem_req_o=0, out_valid_o=0; first request the cycle after rst deasserts.
REQ-035 rst mid-operation: in-flight responses after reset are undefined system behaviour; memory is reset together.

Configuration
REQ-036 Macro FETCH_BYPASS_EN defined: when queue empty, discard_cnt==0 and imem_rvalid_i, out_valid_o=1 same cycle with imem_rdata_i; if out_ready_i, entry not written.
REQ-037 FETCH_BYPASS_EN undefined: no combinational path imem_* to out_*; latency per REQ-025.

Structure
REQ-038 riscv_pkg gains fetch_entry_t (instr) and FETCH_PC_STEP=4.
REQ-039 Storage in sub-module fetch_fifo (DEPTH x ILEN, push/pop/flush, count out).

Verification
REQ-040 Reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> addresses 0,4,8,...; out_pc 0,4,8 in order.
REQ-041 ready=0, DEPTH=4 -> exactly 4 grants, then imem_req_o=0; ready=1 resumes fetch next cycle after pop.
REQ-042 Two outstanding, redirect_i to 0x1000 -> both responses dropped, state FLUSH, then request at 0x1000, out_pc 0x1000.
REQ-043 Redirect same cycle as rvalid and pop -> queue empty, response dropped, out_valid_o=0 next cycle.
REQ-044 gnt held low 5 cycles -> imem_addr_o constant, no pushes.
REQ-045 Bypass on, empty queue, rvalid with ready=1 -> out_valid_o same cycle, occupancy stays 0; bypass off -> out_valid_o one cycle later.
